uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Controller placed directly behind the 8N1+parity UART receiver. It owns the receiver's parity-select configuration and applies changes only between frames. It captures each completed frame with its parity and stop-bit error flags, filters error frames by policy, and buffers accepted frames in a small FIFO. The FIFO is drained by a consumer over a valid/ready handshake, and saturating error statistics are kept for software.

Parameters:
WIDTH, 8, data bits per frame (must match receiver)
DEPTH, 4, FIFO entries (power of two, >=2)
TIMEOUT, 16, max cycles in BUSY without rx_rdy before forced return to IDLE

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rx_line  in  1  serial line, same net as receiver Rx
rx_data  in  WIDTH  receiver Data_Out
rx_rdy  in  1  receiver Out_rdy, 1-cycle pulse
rx_perr  in  1  receiver ParityError
rx_serr  in  1  receiver StopBitError
rx_parity_sel  out  1  drives receiver selected_parity (0 even, 1 odd)
cfg_wr  in  1  config write strobe
cfg_parity  in  1  requested parity on cfg_wr
cfg_drop_err  in  1  on cfg_wr: 1 = discard frames with any error
clr_stats  in  1  clear counters and sticky flags
out_valid  out  1  FIFO head valid
out_data  out  WIDTH  head data
out_perr  out  1  head parity-error flag
out_serr  out  1  head stop-error flag
out_ready  in  1  consumer accepts head
busy  out  1  frame in progress
cfg_pending  out  1  config write not yet applied
overflow  out  1  sticky: frame lost to full FIFO
perr_cnt  out  8  saturating parity-error count
serr_cnt  out  8  saturating stop-error count
drop_cnt  out  8  saturating dropped-frame count (filtered + overflow)

Behaviour:
- Reset: all outputs 0, rx_parity_sel=0, drop_err=0, FIFO empty, state IDLE, timeout counter 0. Reset mid-frame or mid-transfer discards everything immediately.
- State machine (registered):
  - IDLE: pending config present -> apply rx_parity_sel/drop_err on this edge, clear cfg_pending, stay IDLE for this cycle (no frame start taken the same cycle). Else rx_line==0 -> BUSY.
  - BUSY: busy=1; rx_rdy -> IDLE; timeout counter reaches TIMEOUT-1 -> IDLE without capture.
- cfg_wr: latch cfg_parity/cfg_drop_err into a pending register and set cfg_pending. A later cfg_wr before apply overwrites it. cfg_wr in IDLE takes effect at the next IDLE edge, so rx_parity_sel changes 2 cycles after cfg_wr.
- Capture on rx_rdy, in any state:
  - perr_cnt += rx_perr, serr_cnt += rx_serr; each saturates at 255.
  - Frame is dropped if drop_err=1 and (rx_perr|rx_serr): drop_cnt++.
  - Otherwise push {rx_serr, rx_perr, rx_data}. If the FIFO is full and no pop occurs this cycle: frame lost, overflow<=1, drop_cnt++.
- Pop: out_valid & out_ready. out_valid/out_data/flags reflect the FIFO head registers. A push into an empty FIFO gives out_valid=1 the next cycle (1-cycle latency).
- Simultaneous push and pop when full: both proceed, count stays DEPTH.
- Simultaneous push and pop when empty: not possible, since out_valid=0.
- Head fields are stable while out_valid & ~out_ready.
- Pointers are log2(DEPTH) bits with natural wrap. Count is log2(DEPTH)+1 bits.
- clr_stats: zeroes counters and overflow next edge. If it coincides with an increment event, clear wins.

Test Plan:
- Reset, then rx_rdy with rx_data=0xA5, no errors -> out_valid=1 one cycle later, out_data=0xA5; out_ready=1 -> out_valid=0 next cycle.
- cfg_wr cfg_parity=1 while BUSY (rx_line held 0) -> rx_parity_sel stays 0 and cfg_pending=1 until rx_rdy; applied on the following IDLE edge.
- drop_err=1, rx_rdy with rx_perr=1, data 0x3C -> no push; perr_cnt=1, drop_cnt=1. With drop_err=0 the frame is queued with out_perr=1.
- out_ready=0, push DEPTH+1 frames 0x01..0x05 -> 0x05 lost, overflow=1, drop_cnt=1. Then out_ready=1 and push 0x06 in the same cycle -> drain order is 0x02,0x03,0x04,0x06 after 0x01.
- rx_line pulled 0 with no rx_rdy -> busy falls after exactly TIMEOUT cycles, no capture.
- 300 parity-error frames -> perr_cnt=255; clr_stats -> 0. Async rst asserted mid-queue with 3 entries -> out_valid=0 immediately.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: FIFO head handshake between uart_rx_ctrl and its consumer
// Signals:
//   out_valid  head entry present
//   out_data   head data byte
//   out_perr   head parity-error flag
//   out_serr   head stop-bit-error flag
//   out_ready  consumer accepts head this cycle
// Modports: master = controller side, slave = consumer side
interface uart_rx_ctrl_if #(parameter int WIDTH = 8);
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_perr;
  logic             out_serr;
  logic             out_ready;
  modport master (output out_valid, out_data, out_perr, out_serr, input out_ready);
  modport slave (input out_valid, out_data, out_perr, out_serr, output out_ready);
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver controller with between-frame config, error filtering, frame FIFO and error statistics
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   rx_line              serial line (frame-start detect)
//   rx_data/rx_rdy       received frame and its 1-cycle completion pulse
//   rx_perr/rx_serr      parity / stop-bit error flags of the completed frame
//   rx_parity_sel        parity select driven to the receiver (0 even, 1 odd)
//   cfg_wr/cfg_parity/cfg_drop_err  config write, applied only while idle
//   clr_stats            clears counters and overflow (wins over increments)
//   outBus               FIFO head valid/ready handshake
//   busy, cfg_pending    frame in progress, config waiting to be applied
//   overflow             sticky: frame lost to full FIFO
//   perr_cnt/serr_cnt/drop_cnt  saturating statistics
module uart_rx_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_line,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_rdy,
  input  logic             rx_perr,
  input  logic             rx_serr,
  output logic             rx_parity_sel,
  input  logic             cfg_wr,
  input  logic             cfg_parity,
  input  logic             cfg_drop_err,
  input  logic             clr_stats,
  uart_rx_ctrl_if.master   outBus,
  output logic             busy,
  output logic             cfg_pending,
  output logic             overflow,
  output logic [7:0]       perr_cnt,
  output logic [7:0]       serr_cnt,
  output logic [7:0]       drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            stateQ, stateD;
  logic [TW-1:0]     tmoQ, tmoD;
  logic              applyCfg;
  logic              pendParity, pendDrop, dropErr;
  logic [WIDTH+1:0]  mem [DEPTH];
  logic [AW-1:0]     wrPtr, rdPtr;
  logic [AW:0]       cnt;
  logic              headValid, full, pop, accept, doPush, lost, filtered;

  function automatic logic [7:0] sat(input logic [7:0] v, input logic inc);
    return (inc && v != 8'hFF) ? v + 8'd1 : v;
  endfunction

  // Config is only applied from IDLE, and that cycle never starts a frame,
  // so the receiver never sees a parity change mid-frame.
  always_comb begin
    stateD   = stateQ;
    tmoD     = '0;
    applyCfg = 1'b0;
    if (stateQ == IDLE) begin
      applyCfg = cfg_pending;
      stateD   = (!cfg_pending && !rx_line) ? BUSY : IDLE;
    end else begin
      stateD = (rx_rdy || tmoQ == TW'(TIMEOUT - 1)) ? IDLE : BUSY;
      tmoD   = (stateD == BUSY) ? tmoQ + 1'b1 : '0;
    end
  end

  assign busy      = stateQ == BUSY;
  assign headValid = cnt != '0;
  assign full      = cnt == (AW+1)'(DEPTH);
  assign pop       = headValid & outBus.out_ready;
  assign filtered  = rx_rdy & dropErr & (rx_perr | rx_serr);
  assign accept    = rx_rdy & ~filtered;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign doPush    = accept & (~full | pop);
  assign lost      = accept & full & ~pop;

  assign outBus.out_valid = headValid;
  assign {outBus.out_serr, outBus.out_perr, outBus.out_data} = headValid ? mem[rdPtr] : '0;

  always_ff @(posedge clk)
    if (doPush) mem[wrPtr] <= {rx_serr, rx_perr, rx_data};

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stateQ        <= IDLE;
      tmoQ          <= '0;
      pendParity    <= 1'b0;
      pendDrop      <= 1'b0;
      cfg_pending   <= 1'b0;
      rx_parity_sel <= 1'b0;
      dropErr       <= 1'b0;
      wrPtr         <= '0;
      rdPtr         <= '0;
      cnt           <= '0;
      overflow      <= 1'b0;
      perr_cnt      <= '0;
      serr_cnt      <= '0;
      drop_cnt      <= '0;
    end else begin
      stateQ <= stateD;
      tmoQ   <= tmoD;
      if (cfg_wr) begin
        pendParity <= cfg_parity;
        pendDrop   <= cfg_drop_err;
      end
      cfg_pending <= cfg_wr | (cfg_pending & ~applyCfg);
      if (applyCfg) begin
        rx_parity_sel <= pendParity;
        dropErr       <= pendDrop;
      end
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      cnt      <= cnt + (AW+1)'(doPush) - (AW+1)'(pop);
      overflow <= ~clr_stats & (overflow | lost);
      perr_cnt <= clr_stats ? '0 : sat(perr_cnt, rx_rdy & rx_perr);
      serr_cnt <= clr_stats ? '0 : sat(serr_cnt, rx_rdy & rx_serr);
      drop_cnt <= clr_stats ? '0 : sat(drop_cnt, filtered | lost);
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl with directed frames
module tb_uart_rx_ctrl;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_line, rx_rdy, rx_perr, rx_serr;
  logic [7:0] rx_data;
  logic       rx_parity_sel;
  logic       cfg_wr, cfg_parity, cfg_drop_err, clr_stats;
  logic       busy, cfg_pending, overflow;
  logic [7:0] perr_cnt, serr_cnt, drop_cnt;

  int tests = 0;
  int fails = 0;
  logic [9:0] sb [$];

  uart_rx_ctrl_if #(.WIDTH(8)) bus ();

  uart_rx_ctrl #(.WIDTH(8), .DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_line(rx_line), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .rx_perr(rx_perr), .rx_serr(rx_serr), .rx_parity_sel(rx_parity_sel),
    .cfg_wr(cfg_wr), .cfg_parity(cfg_parity), .cfg_drop_err(cfg_drop_err),
    .clr_stats(clr_stats), .outBus(bus.master), .busy(busy), .cfg_pending(cfg_pending),
    .overflow(overflow), .perr_cnt(perr_cnt), .serr_cnt(serr_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] d, input logic pe, input logic se, input bit queued);
    rx_data = d;
    rx_perr = pe;
    rx_serr = se;
    rx_rdy  = 1'b1;
    if (queued) sb.push_back({se, pe, d});
    tick();
    rx_rdy  = 1'b0;
    rx_perr = 1'b0;
    rx_serr = 1'b0;
  endtask

  task automatic cfg(input logic p, input logic d);
    cfg_parity   = p;
    cfg_drop_err = d;
    cfg_wr       = 1'b1;
    tick();
    cfg_wr = 1'b0;
    tick();
  endtask

  // Monitor: every accepted head must match the oldest expected entry.
  initial forever begin
    @(negedge clk);
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pop: got %0h expected none",
                 {bus.out_serr, bus.out_perr, bus.out_data});
      end else chk("head", {bus.out_serr, bus.out_perr, bus.out_data}, sb.pop_front());
    end
  end

  initial begin
    int n;
    rst = 1'b1; rx_line = 1'b1; rx_rdy = 1'b0; rx_perr = 1'b0; rx_serr = 1'b0;
    rx_data = '0; cfg_wr = 1'b0; cfg_parity = 1'b0; cfg_drop_err = 1'b0;
    clr_stats = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_sel", rx_parity_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", cfg_pending, 0);
    chk("rst_cnts", {overflow, perr_cnt, serr_cnt, drop_cnt}, 0);

    frame(8'hA5, 0, 0, 1);
    chk("push_valid", bus.out_valid, 1);
    chk("push_data", bus.out_data, 8'hA5);
    tick();
    chk("pop_valid", bus.out_valid, 0);

    rx_line = 1'b0;
    tick();
    chk("busy_start", busy, 1);
    cfg_parity = 1'b1; cfg_drop_err = 1'b0; cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    chk("busy_cfg_pending", cfg_pending, 1);
    repeat (2) tick();
    chk("busy_sel_held", rx_parity_sel, 0);
    frame(8'h11, 0, 0, 1);
    rx_line = 1'b1;
    chk("rdy_sel_held", rx_parity_sel, 0);
    chk("rdy_pending", cfg_pending, 1);
    chk("rdy_idle", busy, 0);
    tick();
    chk("applied_sel", rx_parity_sel, 1);
    chk("applied_pending", cfg_pending, 0);

    cfg(1, 1);
    chk("drop_cfg_pending", cfg_pending, 0);
    frame(8'h3C, 1, 0, 0);
    chk("drop_perr", perr_cnt, 1);
    chk("drop_cnt", drop_cnt, 1);
    chk("drop_novalid", bus.out_valid, 0);
    cfg(1, 0);
    frame(8'h3C, 1, 0, 1);
    frame(8'h5A, 0, 1, 1);
    repeat (2) tick();
    chk("err_perr", perr_cnt, 2);
    chk("err_serr", serr_cnt, 1);
    chk("err_drop", drop_cnt, 1);

    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_cnts", {perr_cnt, serr_cnt, drop_cnt}, 0);
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) frame(8'(i), 0, 0, i < 5);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_cnt, 1);
    chk("ovf_valid", bus.out_valid, 1);
    chk("ovf_head_stable", bus.out_data, 8'h01);
    bus.out_ready = 1'b1;
    frame(8'h06, 0, 0, 1);
    chk("full_pushpop_drop", drop_cnt, 1);
    repeat (5) tick();
    chk("drained", bus.out_valid, 0);

    rx_line = 1'b0;
    tick();
    rx_line = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    chk("timeout_cycles", n, TIMEOUT);
    chk("timeout_nocapture", bus.out_valid, 0);

    cfg(1, 1);
    for (int i = 0; i < 300; i++) frame(8'(i), 1, 0, 0);
    chk("sat_perr", perr_cnt, 255);
    chk("sat_drop", drop_cnt, 255);
    chk("sat_serr", serr_cnt, 0);
    clr_stats = 1'b1;
    frame(8'hEE, 1, 0, 0);
    clr_stats = 1'b0;
    chk("clr_wins", {overflow, perr_cnt, drop_cnt}, 0);

    cfg(1, 0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) frame(8'h21 + 8'(i), 0, 0, 0);
    chk("pre_rst_valid", bus.out_valid, 1);
    chk("pre_rst_sel", rx_parity_sel, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_sel", rx_parity_sel, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("post_rst_valid", bus.out_valid, 0);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
